dma_controller_rx: RTL and testbench

Receive-side DMA engine, the counterpart of the TX descriptor DMA. Software posts up to 16 free buffer addresses through a register slave. The block accepts 64-bit frame beats from the MAC RX path and writes each frame into the next free buffer through a single-beat memory write master. It then pushes a completion record (address, byte length, error) into a 16-deep done FIFO, which software pops through the same slave.

---
 rtl/dma_controller_rx_if.sv | 37 +++
 rtl/dma_controller_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_dma_controller_rx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_rx_if.sv
// Bus bundle for the RX DMA engine: register slave, RX beat stream and memory write master.
// master = the DMA engine side, slave = the system side that drives it.
interface dma_controller_rx_if;
  logic        wr_en;
  logic [31:0] slave_addr;
  logic [63:0] slave_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic [2:0]  rx_bytes;
  logic        rx_last;
  logic        rx_err;
  logic        rx_ready;
  logic        mem_wr_req;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_strb;
  logic        mem_wr_ack;
  logic        free_empty;
  logic        done_pending;

  modport master (
    input  wr_en, slave_addr, slave_data, rd_en, rd_addr,
    input  rx_valid, rx_data, rx_bytes, rx_last, rx_err, mem_wr_ack,
    output rd_data, rx_ready, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb,
    output free_empty, done_pending
  );

  modport slave (
    output wr_en, slave_addr, slave_data, rd_en, rd_addr,
    output rx_valid, rx_data, rx_bytes, rx_last, rx_err, mem_wr_ack,
    input  rd_data, rx_ready, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb,
    input  free_empty, done_pending
  );
endinterface

// File: rtl/dma_controller_rx.sv
// Receive DMA: writes RX frames into software-posted buffers and queues completion records.
// state | meaning
// IDLE  | wait for a frame, pick a buffer or decide to drop
// XFER  | accept one beat
// WRITE | single-beat memory write, held until ack
// TRUNC | frame exceeded MAX_BEATS, discard to rx_last
// DROP  | no buffer or disabled, discard to rx_last
// CMPL  | push completion record (stalls while done FIFO full)
module dma_controller_rx #(
  parameter int MAX_BEATS = 190,
  parameter int DEPTH     = 16
) (
  input logic clk,
  input logic rst,
  dma_controller_rx_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_1000;
  localparam logic [31:0] ADDR_PUSH   = 32'hFFFF_1008;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_1010;
  localparam logic [31:0] ADDR_POP    = 32'hFFFF_1018;

  typedef enum logic [2:0] {
    ST_IDLE, ST_XFER, ST_WRITE, ST_TRUNC, ST_DROP, ST_CMPL
  } state_e;

  state_e        state_q, state_d;
  logic          enable_q, enable_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [63:0]   cur_addr_q, cur_addr_d;
  logic [8:0]    beat_cnt_q, beat_cnt_d;
  logic [11:0]   len_q, len_d;
  logic          err_q, err_d;
  logic [63:0]   data_q, data_d;
  logic [3:0]    nbytes_q, nbytes_d;
  logic [7:0]    strb_q, strb_d;
  logic          last_q, last_d;
  logic [63:0]   rd_data_q, rd_data_d;
  logic [AW-1:0] free_wp_q, free_wp_d, free_rp_q, free_rp_d;
  logic [CW-1:0] free_cnt_q, free_cnt_d;
  logic [AW-1:0] done_wp_q, done_wp_d, done_rp_q, done_rp_d;
  logic [CW-1:0] done_cnt_q, done_cnt_d;
  logic [63:0]   free_mem_q [DEPTH];
  logic [63:0]   done_mem_q [DEPTH];

  logic          free_empty, free_full, done_empty, done_full;
  logic          free_push, free_pop, done_push, done_pop;
  logic          buf_push_req, drop_inc;
  logic [8:0]    strb_ext;
  logic [63:0]   status_val, record;

  assign free_empty   = (free_cnt_q == '0);
  assign free_full    = (free_cnt_q == CW'(DEPTH));
  assign done_empty   = (done_cnt_q == '0);
  assign done_full    = (done_cnt_q == CW'(DEPTH));
  assign buf_push_req = bus.wr_en && (bus.slave_addr == ADDR_PUSH);
  // A push into a full FIFO is still accepted when the same cycle pops an entry.
  assign free_push    = buf_push_req && (!free_full || free_pop);
  assign done_pop     = bus.rd_en && (bus.rd_addr == ADDR_POP) && !done_empty;
  assign record       = {err_q, 3'b000, len_q, cur_addr_q[47:0]};

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    strb_d     = strb_q;
    last_d     = last_q;
    strb_ext   = '0;
    free_pop   = 1'b0;
    done_push  = 1'b0;
    drop_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          if (enable_q && !free_empty) begin
            free_pop   = 1'b1;
            cur_addr_d = free_mem_q[free_rp_q];
            beat_cnt_d = '0;
            len_d      = '0;
            err_d      = 1'b0;
            state_d    = ST_XFER;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_XFER: begin
        if (bus.rx_valid) begin
          data_d   = bus.rx_data;
          nbytes_d = (bus.rx_last && bus.rx_bytes != 3'd0) ? {1'b0, bus.rx_bytes} : 4'd8;
          strb_ext = (9'd1 << nbytes_d) - 9'd1;
          strb_d   = strb_ext[7:0];
          last_d   = bus.rx_last;
          err_d    = err_q | bus.rx_err;
          if (beat_cnt_q == 9'(MAX_BEATS)) begin
            err_d   = 1'b1;
            state_d = bus.rx_last ? ST_CMPL : ST_TRUNC;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.mem_wr_ack) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          len_d      = len_q + {8'd0, nbytes_q};
          state_d    = last_q ? ST_CMPL : ST_XFER;
        end
      end
      ST_TRUNC: begin
        if (bus.rx_valid && bus.rx_last) begin
          err_d   = err_q | bus.rx_err;
          state_d = ST_CMPL;
        end
      end
      ST_DROP: begin
        if (bus.rx_valid && bus.rx_last) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_CMPL: begin
        if (!done_full) begin
          done_push = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    free_wp_d  = free_wp_q;
    free_rp_d  = free_rp_q;
    free_cnt_d = free_cnt_q;
    done_wp_d  = done_wp_q;
    done_rp_d  = done_rp_q;
    done_cnt_d = done_cnt_q;
    if (free_push) free_wp_d = free_wp_q + AW'(1);
    if (free_pop)  free_rp_d = free_rp_q + AW'(1);
    if (done_push) done_wp_d = done_wp_q + AW'(1);
    if (done_pop)  done_rp_d = done_rp_q + AW'(1);
    case ({free_push, free_pop})
      2'b10:   free_cnt_d = free_cnt_q + CW'(1);
      2'b01:   free_cnt_d = free_cnt_q - CW'(1);
      default: free_cnt_d = free_cnt_q;
    endcase
    case ({done_push, done_pop})
      2'b10:   done_cnt_d = done_cnt_q + CW'(1);
      2'b01:   done_cnt_d = done_cnt_q - CW'(1);
      default: done_cnt_d = done_cnt_q;
    endcase
  end

  always_comb begin
    enable_d   = enable_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.wr_en && bus.slave_addr == ADDR_CTRL) enable_d = bus.slave_data[0];
    if (bus.wr_en && bus.slave_addr == ADDR_STATUS && bus.slave_data[16]) ovf_d = 1'b0;
    if (buf_push_req && !free_push) ovf_d = 1'b1;
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

    status_val        = '0;
    status_val[4:0]   = 5'(free_cnt_q);
    status_val[12:8]  = 5'(done_cnt_q);
    status_val[16]    = ovf_q;
    status_val[47:32] = drop_cnt_q;

    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      case (bus.rd_addr)
        ADDR_CTRL:   rd_data_d = {63'd0, enable_q};
        ADDR_STATUS: rd_data_d = status_val;
        ADDR_POP:    rd_data_d = done_empty ? 64'd0 : done_mem_q[done_rp_q];
        default:     rd_data_d = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      cur_addr_q <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      nbytes_q   <= '0;
      strb_q     <= '0;
      last_q     <= 1'b0;
      rd_data_q  <= '0;
      free_wp_q  <= '0;
      free_rp_q  <= '0;
      free_cnt_q <= '0;
      done_wp_q  <= '0;
      done_rp_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      cur_addr_q <= cur_addr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      data_q     <= data_d;
      nbytes_q   <= nbytes_d;
      strb_q     <= strb_d;
      last_q     <= last_d;
      rd_data_q  <= rd_data_d;
      free_wp_q  <= free_wp_d;
      free_rp_q  <= free_rp_d;
      free_cnt_q <= free_cnt_d;
      done_wp_q  <= done_wp_d;
      done_rp_q  <= done_rp_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and counts gate every read.
  always_ff @(posedge clk) begin
    if (free_push) free_mem_q[free_wp_q] <= bus.slave_data;
    if (done_push) done_mem_q[done_wp_q] <= record;
  end

  assign bus.rx_ready     = (state_q == ST_XFER) || (state_q == ST_TRUNC) || (state_q == ST_DROP);
  assign bus.mem_wr_req   = (state_q == ST_WRITE);
  assign bus.mem_wr_addr  = cur_addr_q + {52'd0, beat_cnt_q, 3'b000};
  assign bus.mem_wr_data  = data_q;
  assign bus.mem_wr_strb  = strb_q;
  assign bus.free_empty   = free_empty;
  assign bus.done_pending = !done_empty;
  assign bus.rd_data      = rd_data_q;
endmodule

// File: tb/tb_dma_controller_rx.sv
// Bench for dma_controller_rx: random frames checked against a queue-based model of buffers,
// memory writes and completion records.
module tb_dma_controller_rx;
  localparam int MAXB  = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_CTRL = 32'hFFFF_1000;
  localparam logic [31:0] A_PUSH = 32'hFFFF_1008;
  localparam logic [31:0] A_STAT = 32'hFFFF_1010;
  localparam logic [31:0] A_POP  = 32'hFFFF_1018;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_controller_rx_if bus ();
  dma_controller_rx #(.MAX_BEATS(MAXB), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [63:0] free_m[$];
  logic [63:0] done_m[$];
  bit en_m = 0;
  bit ovf_m = 0;
  int drop_m = 0;
  bit ack_en = 1;
  int stab_err = 0;

  // Memory responder: random ack, logs accepted writes, flags unstable held requests.
  initial begin
    wr_t prev;
    bit  held;
    held = 0;
    prev = '0;
    bus.mem_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_wr_ack = 1'b0;
      if (bus.mem_wr_req) begin
        if (bus.rx_ready) stab_err++;
        if (held && prev != {bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb}) stab_err++;
        prev = '{addr: bus.mem_wr_addr, data: bus.mem_wr_data, strb: bus.mem_wr_strb};
        if (ack_en && $urandom_range(0, 2) != 0) begin
          bus.mem_wr_ack = 1'b1;
          got_q.push_back(prev);
          held = 0;
        end else begin
          held = 1;
        end
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_mask(input logic [2:0] nb);
    int n;
    n = (nb == 3'd0) ? 8 : int'(nb);
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic [63:0] exp_status();
    logic [63:0] s;
    s = '0;
    s[4:0]   = 5'(free_m.size());
    s[12:8]  = 5'(done_m.size());
    s[16]    = ovf_m;
    s[47:32] = 16'(drop_m);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    free_m.delete();
    done_m.delete();
    got_q.delete();
    exp_q.delete();
    en_m = 0;
    ovf_m = 0;
    drop_m = 0;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [63:0] d);
    bus.wr_en = 1'b1;
    bus.slave_addr = a;
    bus.slave_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [63:0] d);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic push_buf(input logic [63:0] a);
    reg_write(A_PUSH, a);
    if (free_m.size() < DEPTH) free_m.push_back(a);
    else ovf_m = 1;
  endtask

  task automatic set_enable(input bit e);
    reg_write(A_CTRL, {63'd0, e});
    en_m = e;
  endtask

  task automatic send_frame(input int k, input logic [2:0] nb, input logic [15:0] errs,
                            input bit push_start, input logic [63:0] push_addr);
    logic [63:0] dat [16];
    logic [63:0] base;
    logic [11:0] len;
    bit take, err;
    int nw, t;
    take = en_m && (free_m.size() > 0);
    base = take ? free_m.pop_front() : 64'd0;
    if (push_start) begin
      if (free_m.size() < DEPTH) free_m.push_back(push_addr);
      else ovf_m = 1;
    end
    for (int i = 0; i < k; i++) dat[i] = {$urandom, $urandom};
    if (take) begin
      nw = (k > MAXB) ? MAXB : k;
      for (int j = 0; j < nw; j++)
        exp_q.push_back('{addr: base + 64'(8 * j), data: dat[j],
                          strb: (j == k - 1) ? byte_mask(nb) : 8'hFF});
      len = (k > MAXB) ? 12'(8 * MAXB) : 12'(8 * (k - 1) + ((nb == 3'd0) ? 8 : int'(nb)));
      err = (k > MAXB) || ((errs & 16'((1 << k) - 1)) != 16'd0);
      done_m.push_back({err, 3'b000, len, base[47:0]});
    end else if (drop_m < 65535) begin
      drop_m++;
    end
    for (int i = 0; i < k; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = dat[i];
      bus.rx_last  = (i == k - 1);
      bus.rx_bytes = (i == k - 1) ? nb : 3'($urandom);
      bus.rx_err   = errs[i];
      if (i == 0 && push_start) begin
        bus.wr_en = 1'b1;
        bus.slave_addr = A_PUSH;
        bus.slave_data = push_addr;
      end
      t = 0;
      while (!bus.rx_ready && t < 200) begin
        @(negedge clk);
        bus.wr_en = 1'b0;
        t++;
      end
      if (t >= 200) begin
        tests++; fails++;
        $display("FAIL frame_accept: beat %0d never accepted (rx_ready=%0b, want 1)", i, bus.rx_ready);
        break;
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
    end
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    bus.rx_err   = 1'b0;
  endtask

  task automatic wait_writes();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      tests++; fails++;
      $display("FAIL write_timeout: got %0d writes, want %0d", got_q.size(), exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    bus.wr_en = 0; bus.slave_addr = '0; bus.slave_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
    bus.rx_valid = 0; bus.rx_data = '0; bus.rx_bytes = '0; bus.rx_last = 0; bus.rx_err = 0;
    do_reset();
    tests++; if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL rst_rx_ready: got %b want 0", bus.rx_ready); end
    tests++; if (bus.mem_wr_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", bus.mem_wr_req); end
    tests++; if (bus.mem_wr_addr !== 64'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", bus.mem_wr_addr); end
    tests++; if (bus.mem_wr_strb !== 8'd0) begin fails++; $display("FAIL rst_strb: got %h want 0", bus.mem_wr_strb); end
    tests++; if (bus.free_empty !== 1'b1) begin fails++; $display("FAIL rst_free_empty: got %b want 1", bus.free_empty); end
    tests++; if (bus.done_pending !== 1'b0) begin fails++; $display("FAIL rst_done_pending: got %b want 0", bus.done_pending); end
    tests++; if (bus.rd_data !== 64'd0) begin fails++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
    reg_read(A_STAT, rd);
    tests++; if (rd !== exp_status()) begin fails++; $display("FAIL rst_status: got %h want %h", rd, exp_status()); end
    reg_read(A_CTRL, rd);
    tests++; if (rd !== 64'd0) begin fails++; $display("FAIL rst_ctrl: got %h want 0", rd); end
  endtask

  task automatic test_basic_frame();
    logic [63:0] rd;
    set_enable(1);
    push_buf(64'h1000_0000);
    reg_read(A_CTRL, rd);
    tests++; if (rd !== 64'd1) begin fails++; $display("FAIL ctrl_readback: got %h want 1", rd); end
    send_frame(3, 3'd5, 16'd0, 0, 64'd0);
    wait_writes();
    tests++;
    if (got_q.size() != 3) begin fails++; $display("FAIL basic_count: got %0d want 3", got_q.size()); end
    else begin
      tests++; if (got_q[2].addr !== 64'h1000_0010 || got_q[2].strb !== 8'h1F) begin
        fails++; $display("FAIL basic_last: got addr %h strb %h want 10000010 1f", got_q[2].addr, got_q[2].strb); end
      foreach (got_q[j]) begin
        tests++; if (got_q[j] !== exp_q[j]) begin fails++;
          $display("FAIL basic_wr%0d: got %h/%h/%h want %h/%h/%h", j, got_q[j].addr, got_q[j].data,
                   got_q[j].strb, exp_q[j].addr, exp_q[j].data, exp_q[j].strb); end
      end
    end
    got_q.delete(); exp_q.delete();
    reg_read(A_POP, rd);
    void'(done_m.pop_front());
    tests++; if (rd !== 64'h0015_0000_1000_0000) begin fails++; $display("FAIL basic_record: got %h want 0015000010000000", rd); end
  endtask

  task automatic test_no_buffer();
    logic [63:0] rd;
    send_frame(4, 3'd0, 16'd0, 0, 64'd0);
    repeat (10) @(negedge clk);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL nobuf_writes: got %0d want 0", got_q.size()); end
    reg_read(A_STAT, rd);
    tests++; if (rd[47:32] !== 16'd1 || rd[12:8] !== 5'd0) begin fails++;
      $display("FAIL nobuf_status: got drop %0d done %0d want 1 0", rd[47:32], rd[12:8]); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_truncation();
    logic [63:0] rd;
    push_buf(64'h2000_0000);
    send_frame(6, 3'd3, 16'd0, 0, 64'd0);
    wait_writes();
    tests++;
    if (got_q.size() != 4) begin fails++; $display("FAIL trunc_count: got %0d want 4", got_q.size()); end
    else foreach (got_q[j]) begin
      tests++; if (got_q[j] !== exp_q[j]) begin fails++;
        $display("FAIL trunc_wr%0d: got %h/%h want %h/%h", j, got_q[j].addr, got_q[j].data, exp_q[j].addr, exp_q[j].data); end
    end
    got_q.delete(); exp_q.delete();
    reg_read(A_POP, rd);
    tests++; if (rd !== done_m[0] || rd[63] !== 1'b1 || rd[59:48] !== 12'd32) begin fails++;
      $display("FAIL trunc_record: got %h want %h", rd, done_m[0]); end
    void'(done_m.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, e;
    int seen;
    push_buf(64'h3000_0000);
    ack_en = 0;
    send_frame(1, 3'd3, 16'd0, 0, 64'd0);
    for (int c = 0; c < 5; c++) begin
      tests++; if (bus.mem_wr_req !== 1'b1 || bus.mem_wr_addr !== exp_q[0].addr || bus.rx_ready !== 1'b0) begin
        fails++; $display("FAIL hold_c%0d: got req %b addr %h rdy %b want 1 %h 0", c, bus.mem_wr_req,
                          bus.mem_wr_addr, bus.rx_ready, exp_q[0].addr); end
      @(negedge clk);
    end
    ack_en = 1;
    wait_writes();
    reg_read(A_POP, rd);
    e = done_m.pop_front();
    tests++; if (rd !== e) begin fails++; $display("FAIL hold_record: got %h want %h", rd, e); end
    for (int i = 0; i < DEPTH; i++) push_buf({32'h4000_0000 + 32'(i * 'h100), 32'd0});
    for (int i = 0; i < DEPTH; i++) begin
      send_frame($urandom_range(1, 3), 3'($urandom), 16'($urandom_range(0, 1)), 0, 64'd0);
      wait_writes();
    end
    reg_read(A_STAT, rd);
    tests++; if (rd[12:8] !== 5'(done_m.size())) begin fails++; $display("FAIL done_full_cnt: got %0d want %0d", rd[12:8], done_m.size()); end
    push_buf(64'h5000_0000);
    send_frame(1, 3'd0, 16'd0, 0, 64'd0);
    wait_writes();
    bus.rx_valid = 1'b1; bus.rx_last = 1'b1; bus.rx_data = 64'd0;
    seen = 0;
    repeat (6) begin
      if (bus.rx_ready) seen++;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0;
    tests++; if (seen != 0) begin fails++; $display("FAIL cmpl_stall: got rx_ready high %0d cycles want 0", seen); end
    while (done_m.size() > 0) begin
      reg_read(A_POP, rd);
      e = done_m.pop_front();
      tests++; if (rd !== e) begin fails++; $display("FAIL full_pop: got %h want %h", rd, e); end
      if (done_m.size() == DEPTH) begin
        repeat (2) @(negedge clk);
        reg_read(A_STAT, rd);
        tests++; if (rd[12:8] !== 5'(DEPTH)) begin fails++; $display("FAIL refill_cnt: got %0d want %0d", rd[12:8], DEPTH); end
      end
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (got_q[j]) begin
      tests++; if (got_q[j] !== exp_q[j]) begin fails++;
        $display("FAIL b2b_wr%0d: got %h/%h/%h want %h/%h/%h", j, got_q[j].addr, got_q[j].data, got_q[j].strb,
                 exp_q[j].addr, exp_q[j].data, exp_q[j].strb); end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL req_stability: got %0d violations want 0", stab_err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_fifo_boundaries();
    logic [63:0] rd, e;
    for (int i = 0; i < DEPTH + 1; i++) push_buf({32'h0, 32'h6000_0000 + 32'(i * 'h1000)});
    reg_read(A_STAT, rd);
    tests++; if (rd[4:0] !== 5'd16 || rd[16] !== 1'b1 || rd !== exp_status()) begin fails++;
      $display("FAIL fifo_full_ovf: got cnt %0d ovf %b want 16 1", rd[4:0], rd[16]); end
    reg_write(A_STAT, 64'h1_0000);
    ovf_m = 0;
    reg_read(A_STAT, rd);
    tests++; if (rd[16] !== 1'b0 || rd !== exp_status()) begin fails++; $display("FAIL ovf_clear: got %h want %h", rd, exp_status()); end
    send_frame(2, 3'd7, 16'd0, 1, 64'h7000_0000);
    wait_writes();
    reg_read(A_STAT, rd);
    tests++; if (rd[4:0] !== 5'd16 || rd !== exp_status()) begin fails++;
      $display("FAIL push_pop_same: got %h want %h", rd, exp_status()); end
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL pp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (got_q[j]) begin
      tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL pp_wr%0d: got %h want %h", j, got_q[j].addr, exp_q[j].addr); end
    end
    got_q.delete(); exp_q.delete();
    reg_read(A_POP, rd);
    e = done_m.pop_front();
    tests++; if (rd !== e) begin fails++; $display("FAIL pp_record: got %h want %h", rd, e); end
  endtask

  task automatic test_random_frames();
    logic [63:0] rd, e;
    set_enable(1);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) set_enable($urandom_range(0, 3) != 0);
      if (free_m.size() < DEPTH && $urandom_range(0, 1) == 1) push_buf({$urandom, $urandom} & ~64'h7);
      while (done_m.size() >= DEPTH || (done_m.size() > 0 && $urandom_range(0, 2) == 0)) begin
        reg_read(A_POP, rd);
        e = done_m.pop_front();
        tests++; if (rd !== e) begin fails++; $display("FAIL rnd_record: got %h want %h", rd, e); end
      end
      send_frame($urandom_range(1, 6), 3'($urandom),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0, 0, 64'd0);
      wait_writes();
      tests++;
      if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rnd_count%0d: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      else foreach (got_q[j]) begin
        tests++; if (got_q[j] !== exp_q[j]) begin fails++;
          $display("FAIL rnd_wr%0d_%0d: got %h/%h/%h want %h/%h/%h", it, j, got_q[j].addr, got_q[j].data,
                   got_q[j].strb, exp_q[j].addr, exp_q[j].data, exp_q[j].strb); end
      end
      got_q.delete(); exp_q.delete();
    end
    reg_read(A_STAT, rd);
    tests++; if (rd !== exp_status()) begin fails++; $display("FAIL rnd_status: got %h want %h", rd, exp_status()); end
    while (done_m.size() > 0) begin
      reg_read(A_POP, rd);
      e = done_m.pop_front();
      tests++; if (rd !== e) begin fails++; $display("FAIL drain_record: got %h want %h", rd, e); end
    end
    reg_read(A_POP, rd);
    tests++; if (rd !== 64'd0) begin fails++; $display("FAIL empty_pop: got %h want 0", rd); end
  endtask

  task automatic test_reset_during_write();
    logic [63:0] rd, e;
    set_enable(1);
    push_buf(64'h8000_0000);
    ack_en = 0;
    send_frame(1, 3'd0, 16'd0, 0, 64'd0);
    @(negedge clk);
    tests++; if (bus.mem_wr_req !== 1'b1) begin fails++; $display("FAIL pre_rst_req: got %b want 1", bus.mem_wr_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    free_m.delete(); done_m.delete(); got_q.delete(); exp_q.delete();
    en_m = 0; ovf_m = 0; drop_m = 0;
    ack_en = 1;
    tests++; if (bus.mem_wr_req !== 1'b0) begin fails++; $display("FAIL post_rst_req: got %b want 0", bus.mem_wr_req); end
    reg_read(A_STAT, rd);
    tests++; if (rd !== 64'd0) begin fails++; $display("FAIL post_rst_status: got %h want 0", rd); end
    set_enable(1);
    push_buf(64'h9000_0000);
    send_frame(2, 3'd2, 16'd2, 0, 64'd0);
    wait_writes();
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL post_rst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (got_q[j]) begin
      tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL post_rst_wr%0d: got %h want %h", j, got_q[j].addr, exp_q[j].addr); end
    end
    reg_read(A_POP, rd);
    e = done_m.pop_front();
    tests++; if (rd !== e) begin fails++; $display("FAIL post_rst_record: got %h want %h", rd, e); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_no_buffer();
    test_truncation();
    test_back_to_back();
    test_fifo_boundaries();
    test_random_frames();
    test_reset_during_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
